matrix_loader: RTL and testbench

Front-end sequencer for the 2x2 matrix arithmetic coprocessor, on the opposite side of the interface from the result display path. It accepts matrix elements one byte at a time over a valid/ready stream and packs them into operand words A and B. It then issues a single sum/sub command, waits for the coprocessor's done, and holds the 32-bit result until it is acknowledged. A timeout guards against a coprocessor that never answers.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/wait_timer.sv | 36 +++
 rtl/matrix_loader.sv | 180 ++++++++++++++++++
 tb/tb_matrix_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and sizes for the 2x2 matrix loader front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matrix_pkg;

    localparam int ELEM_W = 8;                 // bits per matrix element
    localparam int N_ELEM = 4;                 // elements per 2x2 matrix
    localparam int MAT_W  = ELEM_W * N_ELEM;   // packed matrix width
    localparam int IDX_W  = $clog2(N_ELEM);    // element index width

    localparam logic OP_SUM = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Clearable wait counter that flags when the coprocessor has taken too long.
// Latency: expire is combinational, high on the TIMEOUT-th edge spent running.
// Backpressure: none; the counter holds at zero whenever run is low.
//
// Ports: clk, rst_n (async active-low), clr (sync clear), run (count enable,
// clears when low), expire (high for the cycle whose edge ends the wait).
module wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // count holds the number of edges already spent running, so the edge that
    // sees count == TIMEOUT-1 is the TIMEOUT-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !run) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + 1'b1;
        end
    end

    // TIMEOUT == 0 disables the abort; the counter then just wraps harmlessly.
    assign expire = (TIMEOUT != 0) && run && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/matrix_loader.sv
// Packs streamed bytes into operands A/B, issues one coprocessor op, holds the result.
// Latency: last B accept at edge N -> op_start high N+1..N+2 -> WAIT from edge N+2.
// Backpressure: in_ready only in the load states; result held until res_ack.
//
// Ports: clk, rst_n (async active-low), clr (sync soft clear);
// in_valid/in_data/in_ready element stream, op_sel sampled with the last B element;
// mat_a/mat_b/op_code/op_start command side, op_done/op_result from the coprocessor;
// res_valid/res_data/res_ack result side; load_idx for LEDs; err sticky timeout flag.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [ELEM_W-1:0]    in_data,
    output logic                 in_ready,
    input  logic                 op_sel,
    output logic [MAT_W-1:0]     mat_a,
    output logic [MAT_W-1:0]     mat_b,
    output logic                 op_code,
    output logic                 op_start,
    input  logic                 op_done,
    input  logic [MAT_W-1:0]     op_result,
    output logic                 res_valid,
    output logic [MAT_W-1:0]     res_data,
    input  logic                 res_ack,
    output logic [1:0]           load_idx,
    output logic                 err
);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              op_start_nxt;
    logic              accept;
    logic              idx_last;
    logic              expire;

    assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign accept   = in_valid && in_ready;
    assign idx_last = (idx == IDX_W'(N_ELEM - 1));
    assign load_idx = in_ready ? 2'(idx) : 2'd0;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .run    (state == S_WAIT),
        .expire (expire)
    );

    // ------------------------------------------------------------------
    // Control FSM: state, element index and the command pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD_A;
            idx      <= '0;
            op_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            op_start <= op_start_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        op_start_nxt = 1'b0;
        case (state)
            S_LOAD_A: begin
                if (accept) begin
                    if (idx_last) begin
                        idx_nxt   = '0;
                        state_nxt = S_LOAD_B;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (accept) begin
                    if (idx_last) begin
                        idx_nxt   = '0;
                        state_nxt = S_ISSUE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            // First ISSUE edge raises the registered pulse, the second drops it
            // and enters WAIT, so op_start is high for exactly one cycle.
            S_ISSUE: begin
                if (!op_start) begin
                    op_start_nxt = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            // Done wins over a simultaneous expiry.
            S_WAIT: begin
                if (op_done) begin
                    state_nxt = S_HOLD;
                end else if (expire) begin
                    idx_nxt   = '0;
                    state_nxt = S_LOAD_A;
                end
            end
            S_HOLD: begin
                if (res_ack && res_valid) begin
                    state_nxt = S_LOAD_A;
                end
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = S_LOAD_A;
            end
        endcase
        if (clr) begin
            state_nxt    = S_LOAD_A;
            idx_nxt      = '0;
            op_start_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand packing, op latch, result capture, error flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_a     <= '0;
            mat_b     <= '0;
            op_code   <= OP_SUM;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else if (clr) begin
            mat_a     <= '0;
            mat_b     <= '0;
            op_code   <= OP_SUM;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N_ELEM; k++) begin
                    if (idx == IDX_W'(k)) begin
                        if (state == S_LOAD_A) begin
                            mat_a[k*ELEM_W +: ELEM_W] <= in_data;
                        end else begin
                            mat_b[k*ELEM_W +: ELEM_W] <= in_data;
                        end
                    end
                end
                // Any fresh element acknowledges a previous timeout.
                err <= 1'b0;
                if (state == S_LOAD_B && idx_last) begin
                    op_code <= op_sel;
                end
            end
            if (state == S_WAIT) begin
                if (op_done) begin
                    res_data  <= op_result;
                    res_valid <= 1'b1;
                end else if (expire) begin
                    err <= 1'b1;
                end
            end
            if (state == S_HOLD && res_ack && res_valid) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader (TIMEOUT = 16).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        op_sel = 1'b0;
    logic [31:0] mat_a;
    logic [31:0] mat_b;
    logic        op_code;
    logic        op_start;
    logic        op_done = 1'b0;
    logic [31:0] op_result = 32'h0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ack = 1'b0;
    logic [1:0]  load_idx;
    logic        err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    logic [7:0] a_el [4] = '{8'h00, 8'h02, 8'h01, 8'h00};
    logic [7:0] b_el [4] = '{8'h01, 8'h00, 8'h02, 8'h01};

    matrix_loader #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .op_code   (op_code),
        .op_start  (op_start),
        .op_done   (op_done),
        .op_result (op_result),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ack   (res_ack),
        .load_idx  (load_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Counts each op_start pulse once (value seen just before the edge).
    always @(posedge clk) if (op_start) start_cnt++;

    // Drives one element from a negedge; returns at the negedge after acceptance.
    task automatic send_elem(input logic [7:0] d, input logic sel);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        op_sel   = sel;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_elem_ready: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_all(input logic sel, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            send_elem(a_el[k], sel);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            send_elem(b_el[k], sel);
            if (k < 3) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    // Returns at the negedge where op_start is high (state still ISSUE).
    task automatic wait_start();
        int n = 0;
        while (op_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (op_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_start: op_start=%b required 1 within 50 cycles", op_start);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, op_start, res_valid, err, load_idx} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/start/valid/err/idx=%b required 100000",
                     {in_ready, op_start, res_valid, err, load_idx});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mat_a, mat_b, res_data, op_code} !== 97'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h res=%h op=%b required all zero",
                     mat_a, mat_b, res_data, op_code);
        end
        checks++;
        if (in_ready !== 1'b1 || start_cnt != 0) begin
            errors++;
            $display("FAIL reset_after: in_ready=%b starts=%0d required 1/0", in_ready, start_cnt);
        end
    endtask

    task automatic run_op(input logic sel, input logic [31:0] result, input logic [31:0] exp_res,
                          input logic exp_op, input int max_gap);
        int s0 = start_cnt;
        load_all(sel, max_gap);
        wait_start();
        checks++;
        if (mat_a !== 32'h00010200 || mat_b !== 32'h01020001) begin
            errors++;
            $display("FAIL operands: a=%h b=%h required 00010200/01020001", mat_a, mat_b);
        end
        checks++;
        if (op_code !== exp_op) begin
            errors++;
            $display("FAIL op_code: got %b required %b", op_code, exp_op);
        end
        @(negedge clk);
        op_done   = 1'b1;
        op_result = result;
        @(negedge clk);
        op_done   = 1'b0;
        op_result = 32'h0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp_res) begin
            errors++;
            $display("FAIL result: valid=%b data=%h required 1/%h", res_valid, res_data, exp_res);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL result_hold: valid=%b ready=%b required 1/0", res_valid, in_ready);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || load_idx !== 2'd0) begin
            errors++;
            $display("FAIL after_ack: valid=%b ready=%b idx=%0d required 0/1/0",
                     res_valid, in_ready, load_idx);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL start_count: got %0d pulses required 1", start_cnt - s0);
        end
    endtask

    task automatic test_sum();
        run_op(1'b0, 32'h01030201, 32'h01030201, 1'b0, 0);
    endtask

    task automatic test_sub();
        run_op(1'b1, 32'hFFFF02FF, 32'hFFFF02FF, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int s0 = start_cnt;
        int bad_rdy = 0;
        int bad_res = 0;
        load_all(1'b0, 3);
        wait_start();
        // Offer a junk element all through ISSUE/WAIT/HOLD; none may be taken.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        if (in_ready !== 1'b0) bad_rdy++;
        op_done   = 1'b1;
        op_result = 32'h01030201;
        @(negedge clk);
        op_done   = 1'b0;
        op_result = 32'h0;
        for (int c = 0; c < 20; c++) begin
            if (in_ready !== 1'b0) bad_rdy++;
            if (res_valid !== 1'b1 || res_data !== 32'h01030201) bad_res++;
            @(negedge clk);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL bp_ready: in_ready high in %0d busy cycles required 0", bad_rdy);
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL bp_result_stable: %0d unstable cycles required 0", bad_res);
        end
        checks++;
        if (mat_a !== 32'h00010200 || mat_b !== 32'h01020001) begin
            errors++;
            $display("FAIL bp_operands: a=%h b=%h required 00010200/01020001", mat_a, mat_b);
        end
        in_valid = 1'b0;
        res_ack  = 1'b1;
        @(negedge clk);
        res_ack  = 1'b0;
        checks++;
        if (start_cnt - s0 != 1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_start_once: pulses=%0d valid=%b required 1/0", start_cnt - s0, res_valid);
        end
    endtask

    task automatic test_stray_done();
        op_done   = 1'b1;
        op_result = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        op_done   = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h01030201) begin
            errors++;
            $display("FAIL stray_load: valid=%b data=%h required 0/01030201", res_valid, res_data);
        end
        load_all(1'b0, 0);
        wait_start();
        op_done = 1'b1;            // lands on the ISSUE edge
        @(negedge clk);
        op_done = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h01030201) begin
            errors++;
            $display("FAIL stray_issue: valid=%b data=%h required 0/01030201", res_valid, res_data);
        end
        op_done   = 1'b1;
        op_result = 32'h0A0B0C0D;
        @(negedge clk);
        op_done   = 1'b0;
        op_result = 32'h0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h0A0B0C0D) begin
            errors++;
            $display("FAIL stray_real_done: valid=%b data=%h required 1/0a0b0c0d", res_valid, res_data);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_timeout();
        load_all(1'b1, 0);
        wait_start();
        repeat (16) @(negedge clk);
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b ready=%b required 0/0 at 15 WAIT cycles", err, in_ready);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1 || res_valid !== 1'b0 || load_idx !== 2'd0) begin
            errors++;
            $display("FAIL timeout_abort: err=%b ready=%b valid=%b idx=%0d required 1/1/0/0",
                     err, in_ready, res_valid, load_idx);
        end
        send_elem(8'h55, 1'b0);
        checks++;
        if (err !== 1'b0 || load_idx !== 2'd1 || mat_a[7:0] !== 8'h55) begin
            errors++;
            $display("FAIL timeout_clear: err=%b idx=%0d a0=%h required 0/1/55", err, load_idx, mat_a[7:0]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (load_idx !== 2'd0 || mat_a !== 32'h0) begin
            errors++;
            $display("FAIL clr_load: idx=%0d a=%h required 0/0", load_idx, mat_a);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        for (int k = 0; k < 4; k++) send_elem(a_el[k], 1'b0);
        for (int k = 0; k < 2; k++) send_elem(b_el[k], 1'b0);
        checks++;
        if (load_idx !== 2'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_load_idx: idx=%0d ready=%b required 2/1", load_idx, in_ready);
        end
        s0 = start_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mat_a, mat_b, load_idx, op_start, res_valid} !== 68'h0) begin
            errors++;
            $display("FAIL mid_reset_async: a=%h b=%h idx=%0d start=%b valid=%b required zero",
                     mat_a, mat_b, load_idx, op_start, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt != s0 || in_ready !== 1'b1 || load_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_after: pulses=%0d ready=%b idx=%0d required 0/1/0",
                     start_cnt - s0, in_ready, load_idx);
        end
    endtask

    task automatic test_clr_wait();
        int s0;
        load_all(1'b1, 0);
        wait_start();
        @(negedge clk);
        s0 = start_cnt;
        clr       = 1'b1;
        op_done   = 1'b1;
        op_result = 32'h12345678;
        @(negedge clk);
        clr       = 1'b0;
        op_done   = 1'b0;
        op_result = 32'h0;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_wait_result: valid=%b data=%h err=%b required 0/0/0", res_valid, res_data, err);
        end
        checks++;
        if (mat_a !== 32'h0 || mat_b !== 32'h0 || op_code !== 1'b0 || in_ready !== 1'b1 || load_idx !== 2'd0) begin
            errors++;
            $display("FAIL clr_wait_state: a=%h b=%h op=%b ready=%b idx=%0d required 0/0/0/1/0",
                     mat_a, mat_b, op_code, in_ready, load_idx);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL clr_no_start: %0d pulses after clr required 0", start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_sub();
        test_back_to_back();
        test_stray_done();
        test_timeout();
        test_reset_mid();
        test_clr_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
